// File: rtl/rom_streamer.sv
// Pattern-ROM reader: walks start..end addresses (mod 2^ADDR_W), absorbs the
// ROM's 1-cycle registered read latency and streams bytes over valid/ready.
module rom_streamer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_start_a, r_end_a, r_cnt, r_addr;
  logic              r_loop, r_infl, r_infl_last;
  logic [DATA_W-1:0] r_mem      [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_count;

  logic              w_pop, w_issue, w_at_end, w_loop_eff, w_fin;
  logic [CNT_W:0]    w_occ;

  assign w_pop      = (r_count != '0) & m_ready;
  // Slots committed after this cycle: stored + in flight - leaving now.
  assign w_occ      = {1'b0, r_count} + (CNT_W+1)'(r_infl) - (CNT_W+1)'(w_pop);
  assign w_issue    = (r_state == S_RUN) && (w_occ < (CNT_W+1)'(FIFO_DEPTH));
  assign w_at_end   = (r_cnt == r_end_a);
  assign w_loop_eff = r_loop & ~stop;
  assign w_fin      = (r_state == S_DRAIN) && !r_infl && (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_start_a   <= '0;
      r_end_a     <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_loop      <= 1'b0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
    end else begin
      r_infl      <= w_issue;
      r_infl_last <= w_issue & w_at_end;
      if (r_infl) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(r_infl) - CNT_W'(w_pop);
      if (stop) r_loop <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_start_a <= start_addr;
          r_end_a   <= end_addr;
          r_cnt     <= start_addr;
          r_loop    <= loop;
          r_state   <= S_RUN;
        end
        S_RUN: if (w_issue) begin
          r_addr <= r_cnt;
          if (w_at_end) begin
            r_cnt <= r_start_a;
            if (!w_loop_eff) r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        S_DRAIN: if (w_fin) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset; outputs are masked by m_valid.
  always_ff @(posedge clk) begin
    if (r_infl) begin
      r_mem[r_wr]      <= rom_data;
      r_mem_last[r_wr] <= r_infl_last;
    end
  end

  assign m_valid  = (r_count != '0);
  assign m_data   = m_valid ? r_mem[r_rd] : '0;
  assign m_last   = m_valid & r_mem_last[r_rd];
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = w_fin & ~reset;
  assign rom_addr = w_issue ? r_cnt : r_addr;
endmodule

// File: tb/tb_rom_streamer.sv
// Scoreboard bench for rom_streamer: stimulus queues expected words, a
// negedge monitor pops/compares every handshake and checks stall stability.
module tb_rom_streamer;
  logic       clk = 1'b0;
  logic       reset, start, loop, stop, m_ready;
  logic [3:0] start_addr, end_addr, rom_addr;
  logic [7:0] rom_data, m_data;
  logic       busy, done, m_valid, m_last;

  always #5 clk = ~clk;

  rom_streamer #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .loop(loop), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic logic [7:0] romf(input logic [3:0] a);
    logic hi;
    hi = (a == 4'd0) || (a == 4'd1) || (a == 4'd3) || (a == 4'd7) ||
         (a == 4'd10) || (a == 4'd13) || (a == 4'd15);
    return {hi, 3'b000, a};
  endfunction

  always_ff @(posedge clk) rom_data <= romf(rom_addr);

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t q[$];
  int   errs = 0, checks = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares each accepted word and holds the head across stalls.
  logic [8:0] held;
  bit         stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) stalled = 1'b0;
    else begin
      if (stalled) chk("stall_hold", {m_valid, m_data, m_last}, {1'b1, held});
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        stalled = 1'b0;
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_word: got %0h/%0b expected none", m_data, m_last);
        end else begin
          e = q.pop_front();
          chk("word", {m_data, m_last}, {e.d, e.l});
        end
      end else if (m_valid) begin
        stalled = 1'b1;
        held    = {m_data, m_last};
      end else stalled = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    q.push_back({d, l});
  endtask

  task automatic do_start(input logic [3:0] s, input logic [3:0] e, input logic lp);
    start_addr = s; end_addr = e; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    checks++;
    if (busy) begin errs++; $display("FAIL %s_timeout: busy still %0b expected 0", nm, busy); end
  endtask

  task automatic finish_pass(input string nm, input int exp_done);
    tick(2);
    chk({nm, "_queue_empty"}, q.size(), 0);
    chk({nm, "_done_count"}, done_cnt, exp_done);
    chk({nm, "_busy_low"}, busy, 0);
  endtask

  logic [15:0] pat = 16'b1011_0010_0110_1101;

  initial begin
    reset = 1'b1; start = 1'b0; loop = 1'b0; stop = 1'b0; m_ready = 1'b1;
    start_addr = '0; end_addr = '0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;
    tick();

    // Single pass 0..3, full rate
    push(8'h80, 0); push(8'h81, 0); push(8'h02, 0); push(8'h83, 1);
    do_start(4'd0, 4'd3, 1'b0);
    chk("lat_c1", m_valid, 0);
    tick();
    chk("lat_c2", m_valid, 0);
    tick();
    chk("lat_c3", {m_valid, m_data}, {1'b1, 8'h80});
    tick(4);
    chk("done_timing", {done, busy}, 2'b11);
    tick();
    chk("busy_after_done", busy, 0);
    finish_pass("single", 1);

    // Wrap 14..1
    push(8'h0E, 0); push(8'h8F, 0); push(8'h80, 0); push(8'h81, 1);
    do_start(4'd14, 4'd1, 1'b0);
    wait_idle("wrap");
    finish_pass("wrap", 2);

    // Backpressure 5..9
    push(8'h05, 0); push(8'h06, 0); push(8'h87, 0); push(8'h08, 0); push(8'h09, 1);
    do_start(4'd5, 4'd9, 1'b0);
    for (int i = 0; i < 200 && busy; i++) begin
      m_ready = pat[i % 16];
      tick();
    end
    m_ready = 1'b1;
    wait_idle("bp");
    finish_pass("bp", 3);

    // Loop 2..3, stop during second pass, stray start ignored
    push(8'h02, 0); push(8'h83, 1); push(8'h02, 0); push(8'h83, 1);
    do_start(4'd2, 4'd3, 1'b1);
    tick();
    start_addr = 4'd9; end_addr = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; loop = 1'b0;
    wait_idle("loop");
    finish_pass("loop", 4);

    // Reset 3 cycles into a 0..15 pass
    do_start(4'd0, 4'd15, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_state", {m_valid, busy, done}, 3'b000);
    reset = 1'b0;
    tick(3);
    chk("midrst_quiet", {m_valid, busy, done_cnt[7:0]}, {2'b00, 8'd4});
    push(8'h8A, 1);
    do_start(4'd10, 4'd10, 1'b0);
    wait_idle("one_word");
    finish_pass("one_word", 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
